// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types and constants.
// Used by the ID/EX and EX/MEM/WB stages.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
  } m_ctrl_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// EX -> MEM handshake bundle.
// master = EX producer, slave = MEM consumer.
interface mem_wb_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) ();
  import mips_pkg::*;

  logic              ex_valid;
  logic              ex_ready;
  logic [DATA_W-1:0] ex_alu_result;
  logic [DATA_W-1:0] ex_store_data;
  logic [REG_AW-1:0] ex_dest;
  logic              ex_reg_write;
  logic              ex_mem_to_reg;
  logic              ex_mem_read;
  logic              ex_mem_write;

  modport master (
    output ex_valid,
    input  ex_ready,
    output ex_alu_result,
    output ex_store_data,
    output ex_dest,
    output ex_reg_write,
    output ex_mem_to_reg,
    output ex_mem_read,
    output ex_mem_write
  );

  modport slave (
    input  ex_valid,
    output ex_ready,
    input  ex_alu_result,
    input  ex_store_data,
    input  ex_dest,
    input  ex_reg_write,
    input  ex_mem_to_reg,
    input  ex_mem_read,
    input  ex_mem_write
  );

endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline register with valid bit, hold and bubble insert.
// Empty slots carry all-zero payload.
module pipe_stage_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hold,
  input  logic         bubble,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic         valid_d, valid_q;
  logic [W-1:0] data_d, data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (!hold) begin
      if (in_valid && !bubble) begin
        valid_d = 1'b1;
        data_d  = in_data;
      end else begin
        valid_d = 1'b0;
        data_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MIPS back end: EX/MEM and MEM/WB registers, data memory
// port, write-back select, forwarding and retire tracking.
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic              ex_reg_write,
  input  logic              ex_mem_to_reg,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              mem_stall,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              dmem_re,
  output logic              dmem_we,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              fwd_mem_valid,
  output logic [REG_AW-1:0] fwd_mem_dest,
  output logic [DATA_W-1:0] fwd_mem_data,
  output logic              fwd_wb_valid,
  output logic [REG_AW-1:0] fwd_wb_dest,
  output logic [DATA_W-1:0] fwd_wb_data,
  output logic              load_pending,
  output logic              protocol_err,
  output logic [31:0]       retire_count
);
  import mips_pkg::*;

  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] st;
    logic [REG_AW-1:0] dest;
    wb_ctrl_t          wb;
    m_ctrl_t           m;
  } ex_mem_t;

  typedef struct packed {
    logic [REG_AW-1:0] dest;
    logic              reg_write;
    logic [DATA_W-1:0] data;
  } mem_wb_t;

  localparam logic [REG_AW-1:0] ZERO_REG = REG_AW'(REG_ZERO);

  ex_mem_t exm_in, exm_q;
  mem_wb_t mwb_in, mwb_q;
  logic    exm_valid, mwb_valid;
  logic    exm_dest_nz, mwb_dest_nz;
  logic    accept;

  logic        protocol_err_d, protocol_err_q;
  logic [31:0] retire_count_d, retire_count_q;

  assign ex_ready = !mem_stall;
  assign accept   = ex_valid && !mem_stall;

  always_comb begin
    exm_in              = '0;
    exm_in.alu          = ex_alu_result;
    exm_in.st           = ex_store_data;
    exm_in.dest         = ex_dest;
    exm_in.wb.reg_write = ex_reg_write;
    exm_in.wb.mem_to_reg = ex_mem_to_reg;
    exm_in.m.mem_read   = ex_mem_read;
    exm_in.m.mem_write  = ex_mem_write;
  end

  pipe_stage_reg #(
    .W($bits(ex_mem_t))
  ) u_ex_mem (
    .clk      (clk),
    .rst      (rst),
    .hold     (mem_stall),
    .bubble   (1'b0),
    .in_valid (ex_valid),
    .in_data  (exm_in),
    .out_valid(exm_valid),
    .out_data (exm_q)
  );

  // Only combinational path through the stage: rdata -> WB data.
  always_comb begin
    mwb_in           = '0;
    mwb_in.dest      = exm_q.dest;
    mwb_in.reg_write = exm_q.wb.reg_write;
    mwb_in.data      = exm_q.wb.mem_to_reg ? dmem_rdata
                                           : exm_q.alu;
  end

  pipe_stage_reg #(
    .W($bits(mem_wb_t))
  ) u_mem_wb (
    .clk      (clk),
    .rst      (rst),
    .hold     (1'b0),
    .bubble   (mem_stall),
    .in_valid (exm_valid),
    .in_data  (mwb_in),
    .out_valid(mwb_valid),
    .out_data (mwb_q)
  );

  assign exm_dest_nz = (exm_q.dest != ZERO_REG);
  assign mwb_dest_nz = (mwb_q.dest != ZERO_REG);

  assign dmem_addr  = exm_q.alu;
  assign dmem_wdata = exm_q.st;
  assign dmem_we    = exm_valid && exm_q.m.mem_write;
  assign dmem_re    = exm_valid && exm_q.m.mem_read
                      && !exm_q.m.mem_write;

  assign rf_we    = mwb_valid && mwb_q.reg_write && mwb_dest_nz;
  assign rf_waddr = mwb_q.dest;
  assign rf_wdata = mwb_q.data;

  assign fwd_mem_valid = exm_valid && exm_q.wb.reg_write
                         && !exm_q.wb.mem_to_reg && exm_dest_nz;
  assign fwd_mem_dest  = exm_q.dest;
  assign fwd_mem_data  = exm_q.alu;

  assign fwd_wb_valid = rf_we;
  assign fwd_wb_dest  = rf_waddr;
  assign fwd_wb_data  = rf_wdata;

  assign load_pending = exm_valid && exm_q.m.mem_read
                        && exm_q.wb.reg_write && exm_dest_nz;

  always_comb begin
    protocol_err_d = protocol_err_q;
    if (accept && ex_mem_read && ex_mem_write) begin
      protocol_err_d = 1'b1;
    end
    retire_count_d = retire_count_q + {31'b0, mwb_valid};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      protocol_err_q <= 1'b0;
      retire_count_q <= '0;
    end else begin
      protocol_err_q <= protocol_err_d;
      retire_count_q <= retire_count_d;
    end
  end

  assign protocol_err = protocol_err_q;
  assign retire_count = retire_count_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed vectors, corner
// sequences and a randomized run against a slot model.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_stall;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_re, dmem_we;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        fwd_mem_valid, fwd_wb_valid;
  logic [4:0]  fwd_mem_dest, fwd_wb_dest;
  logic [31:0] fwd_mem_data, fwd_wb_data;
  logic        load_pending, protocol_err;
  logic [31:0] retire_count;

  int checks = 0;
  int errors = 0;
  int commits = 0;

  mem_wb_stage_if ex_if ();

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a == 32'h20) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  assign dmem_rdata = mem_rd(dmem_addr);

  always @(posedge clk)
    if (!rst && dmem_we && !mem_stall) commits <= commits + 1;

  mem_wb_stage dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_if.ex_valid),
    .ex_ready     (ex_if.ex_ready),
    .ex_alu_result(ex_if.ex_alu_result),
    .ex_store_data(ex_if.ex_store_data),
    .ex_dest      (ex_if.ex_dest),
    .ex_reg_write (ex_if.ex_reg_write),
    .ex_mem_to_reg(ex_if.ex_mem_to_reg),
    .ex_mem_read  (ex_if.ex_mem_read),
    .ex_mem_write (ex_if.ex_mem_write),
    .mem_stall    (mem_stall),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_re      (dmem_re),
    .dmem_we      (dmem_we),
    .dmem_rdata   (dmem_rdata),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .fwd_mem_valid(fwd_mem_valid),
    .fwd_mem_dest (fwd_mem_dest),
    .fwd_mem_data (fwd_mem_data),
    .fwd_wb_valid (fwd_wb_valid),
    .fwd_wb_dest  (fwd_wb_dest),
    .fwd_wb_data  (fwd_wb_data),
    .load_pending (load_pending),
    .protocol_err (protocol_err),
    .retire_count (retire_count)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit v,
                       input logic [31:0] alu,
                       input logic [31:0] st,
                       input logic [4:0] dest,
                       input bit rw, input bit m2r,
                       input bit mr, input bit mw);
    ex_if.ex_valid      = v;
    ex_if.ex_alu_result = alu;
    ex_if.ex_store_data = st;
    ex_if.ex_dest       = dest;
    ex_if.ex_reg_write  = rw;
    ex_if.ex_mem_to_reg = m2r;
    ex_if.ex_mem_read   = mr;
    ex_if.ex_mem_write  = mw;
  endtask

  typedef struct {
    logic [31:0] alu;
    logic [31:0] st;
    logic [4:0]  dest;
    bit rw, m2r, mr, mw;
    bit e_re, e_we, e_fwd, e_lp, e_rfwe;
    logic [31:0] e_wd;
  } vec_t;

  typedef struct {
    bit v;
    logic [31:0] alu, st;
    logic [4:0] dest;
    bit rw, m2r, mr, mw;
  } ins_t;

  typedef struct {
    bit v;
    logic [4:0] dest;
    bit rw;
    logic [31:0] data;
  } wb_t;

  vec_t tbl[6];
  ins_t ms, nms, bub_m;
  wb_t  ws, nws, bub_w;
  logic [31:0] cnt;
  int ec;
  int c0;

  initial begin
    tbl[0] = '{32'h10, 0, 8, 1,0,0,0, 0,0,1,0,1, 32'h10};
    tbl[1] = '{32'h20, 0, 9, 1,1,1,0, 1,0,0,1,1,
               32'hDEADBEEF};
    tbl[2] = '{32'h7, 0, 0, 1,0,0,0, 0,0,0,0,0, 32'h7};
    tbl[3] = '{32'h4, 32'h55, 0, 0,0,0,1, 0,1,0,0,0, 32'h4};
    tbl[4] = '{32'h44, 0, 0, 1,1,1,0, 1,0,0,0,0,
               32'h0044FFBB};
    tbl[5] = '{32'hFFFFFFFF, 32'hAAAA5555, 31,
               1,0,0,0, 0,0,1,0,1, 32'hFFFFFFFF};
    bub_m = '{0, 0, 0, 0, 0, 0, 0, 0};
    bub_w = '{0, 0, 0, 0};

    rst = 1'b1;
    mem_stall = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_dmem_we", dmem_we, 0);
    chk("rst_dmem_re", dmem_re, 0);
    chk("rst_dmem_addr", dmem_addr, 0);
    chk("rst_fwd_mem", fwd_mem_valid, 0);
    chk("rst_fwd_wb", fwd_wb_valid, 0);
    chk("rst_lp", load_pending, 0);
    chk("rst_perr", protocol_err, 0);
    chk("rst_retire", retire_count, 0);
    chk("rst_ready", ex_if.ex_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    // Directed single-instruction flows
    ec = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1, tbl[i].alu, tbl[i].st, tbl[i].dest,
            tbl[i].rw, tbl[i].m2r, tbl[i].mr, tbl[i].mw);
      @(negedge clk);
      ex_if.ex_valid = 1'b0;
      chk($sformatf("v%0d_re", i), dmem_re, tbl[i].e_re);
      chk($sformatf("v%0d_we", i), dmem_we, tbl[i].e_we);
      chk($sformatf("v%0d_addr", i), dmem_addr, tbl[i].alu);
      chk($sformatf("v%0d_wdat", i), dmem_wdata, tbl[i].st);
      chk($sformatf("v%0d_fwd", i), fwd_mem_valid,
          tbl[i].e_fwd);
      chk($sformatf("v%0d_fdst", i), fwd_mem_dest,
          tbl[i].dest);
      chk($sformatf("v%0d_lp", i), load_pending, tbl[i].e_lp);
      @(negedge clk);
      chk($sformatf("v%0d_rfwe", i), rf_we, tbl[i].e_rfwe);
      chk($sformatf("v%0d_wadr", i), rf_waddr, tbl[i].dest);
      chk($sformatf("v%0d_wdata", i), rf_wdata, tbl[i].e_wd);
      chk($sformatf("v%0d_fwb", i), fwd_wb_valid,
          tbl[i].e_rfwe);
      chk($sformatf("v%0d_ret0", i), retire_count, ec);
      @(negedge clk);
      ec++;
      chk($sformatf("v%0d_ret1", i), retire_count, ec);
    end

    // Store held under a 3-cycle stall, next op waiting
    drive(1, 32'h4, 32'h55, 0, 0, 0, 0, 1);
    @(negedge clk);
    c0 = commits;
    drive(1, 32'h99, 0, 3, 1, 0, 0, 0);
    mem_stall = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("st%0d_we", k), dmem_we, 1);
      chk($sformatf("st%0d_rdy", k), ex_if.ex_ready, 0);
      chk($sformatf("st%0d_wd", k), dmem_wdata, 32'h55);
      chk($sformatf("st%0d_rfwe", k), rf_we, 0);
      chk($sformatf("st%0d_ret", k), retire_count, ec);
      @(negedge clk);
    end
    mem_stall = 1'b0;
    #1;
    chk("rel_rdy", ex_if.ex_ready, 1);
    chk("rel_we", dmem_we, 1);
    chk("rel_nocommit", commits, c0);
    @(negedge clk);
    ex_if.ex_valid = 1'b0;
    chk("rel_commit", commits, c0 + 1);
    chk("rel_we0", dmem_we, 0);
    chk("rel_fwd", fwd_mem_valid, 1);
    chk("rel_fdst", fwd_mem_dest, 3);
    chk("rel_rfwe", rf_we, 0);
    chk("rel_ret", retire_count, ec);
    @(negedge clk);
    chk("rel_ret1", retire_count, ec + 1);
    chk("add_rfwe", rf_we, 1);
    chk("add_wadr", rf_waddr, 3);
    chk("add_wdat", rf_wdata, 32'h99);
    @(negedge clk);
    ec += 2;
    chk("rel_ret2", retire_count, ec);
    chk("rel_once", commits, c0 + 1);

    // Randomized run against a two-slot model
    ms = bub_m;
    ws = bub_w;
    cnt = ec;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      chk("r_re", dmem_re, ms.v && ms.mr && !ms.mw);
      chk("r_we", dmem_we, ms.v && ms.mw);
      chk("r_addr", dmem_addr, ms.alu);
      chk("r_wdat", dmem_wdata, ms.st);
      chk("r_fwd", fwd_mem_valid,
          ms.v && ms.rw && !ms.m2r && ms.dest != 0);
      chk("r_fdat", fwd_mem_data, ms.alu);
      chk("r_lp", load_pending,
          ms.v && ms.mr && ms.rw && ms.dest != 0);
      chk("r_rfwe", rf_we, ws.v && ws.rw && ws.dest != 0);
      chk("r_wadr", rf_waddr, ws.dest);
      chk("r_wdat", rf_wdata, ws.data);
      chk("r_ret", retire_count, cnt);
      chk("r_perr", protocol_err, 0);
      if (!mem_stall) begin
        int kind;
        kind = $urandom_range(0, 3);
        drive($urandom_range(0, 3) != 0,
              ($urandom_range(0, 1) != 0) ?
                32'($urandom_range(0, 63)) : $urandom,
              $urandom,
              ($urandom_range(0, 5) == 0) ?
                5'd0 : 5'($urandom_range(1, 31)),
              kind != 2,
              kind == 1 || (kind == 3 && $urandom_range(0, 1) != 0),
              kind == 1,
              kind == 2);
      end
      mem_stall = ($urandom_range(0, 3) == 0);
      #1;
      chk("r_rdy", ex_if.ex_ready, !mem_stall);
      @(posedge clk);
      nms = '{ex_if.ex_valid, ex_if.ex_alu_result,
              ex_if.ex_store_data, ex_if.ex_dest,
              ex_if.ex_reg_write, ex_if.ex_mem_to_reg,
              ex_if.ex_mem_read, ex_if.ex_mem_write};
      if (mem_stall || !ms.v) nws = bub_w;
      else nws = '{1, ms.dest, ms.rw,
                   ms.m2r ? mem_rd(ms.alu) : ms.alu};
      cnt = cnt + (ws.v ? 1 : 0);
      ws = nws;
      if (!mem_stall) ms = nms.v ? nms : bub_m;
    end
    @(negedge clk);
    mem_stall = 1'b0;
    ex_if.ex_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Illegal read+write control; error stays sticky
    chk("ill_pre", protocol_err, 0);
    drive(1, 32'h30, 32'h1, 4, 0, 0, 1, 1);
    @(negedge clk);
    ex_if.ex_valid = 1'b0;
    chk("ill_we", dmem_we, 1);
    chk("ill_re", dmem_re, 0);
    chk("ill_perr", protocol_err, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("ill_stk%0d", k), protocol_err, 1);
    end

    // Reset with two instructions in flight and a stall
    drive(1, 32'h11, 0, 5, 1, 0, 0, 0);
    @(negedge clk);
    drive(1, 32'h8, 32'h77, 0, 0, 0, 0, 1);
    @(negedge clk);
    ex_if.ex_valid = 1'b0;
    chk("pre_rfwe", rf_we, 1);
    chk("pre_we", dmem_we, 1);
    rst = 1'b1;
    mem_stall = 1'b1;
    c0 = commits;
    @(negedge clk);
    rst = 1'b0;
    mem_stall = 1'b0;
    #1;
    chk("mr_rfwe", rf_we, 0);
    chk("mr_we", dmem_we, 0);
    chk("mr_fwdm", fwd_mem_valid, 0);
    chk("mr_fwdw", fwd_wb_valid, 0);
    chk("mr_fdst", fwd_mem_dest, 0);
    chk("mr_lp", load_pending, 0);
    chk("mr_ret", retire_count, 0);
    chk("mr_perr", protocol_err, 0);
    @(negedge clk);
    chk("mr_nocommit", commits, c0);
    chk("mr_rfwe1", rf_we, 0);
    chk("mr_ret1", retire_count, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
Back end of the 5-stage MIPS pipeline, taking over where the ID2EXE register and ALU leave off. It holds the EX/MEM and MEM/WB pipeline registers, drives the data-memory port, and selects write-back data. It is the write-side counterpart of the register file read interface: it drives RegWrite, wr_reg and wr_data. It also returns forwarding and load-use information to the EX/ID hazard logic.

Parameters:
DATA_W, 32, data/address width (word-addressed, PC step 1)
REG_AW, 5, register index width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ex_valid  in  1  EX stage presents an instruction
ex_ready  out  1  stage accepts EX result this cycle (= !mem_stall)
ex_alu_result  in  DATA_W  ALU result / memory address
ex_store_data  in  DATA_W  rt value for stores
ex_dest  in  REG_AW  destination register (post RegDst mux)
ex_reg_write  in  1  WB control: write register
ex_mem_to_reg  in  1  WB control: 1 = memory data, 0 = ALU result
ex_mem_read  in  1  M control: load
ex_mem_write  in  1  M control: store
mem_stall  in  1  data memory not ready; freeze EX/MEM
dmem_addr  out  DATA_W  memory address
dmem_wdata  out  DATA_W  store data
dmem_re  out  1  read enable
dmem_we  out  1  write enable
dmem_rdata  in  DATA_W  read data, combinational in same cycle
rf_we  out  1  register file RegWrite
rf_waddr  out  REG_AW  register file wr_reg
rf_wdata  out  DATA_W  register file wr_data
fwd_mem_valid  out  1  MEM-stage ALU result forwardable
fwd_mem_dest  out  REG_AW  MEM-stage destination
fwd_mem_data  out  DATA_W  MEM-stage ALU result
fwd_wb_valid  out  1  = rf_we
fwd_wb_dest  out  REG_AW  = rf_waddr
fwd_wb_data  out  DATA_W  = rf_wdata
load_pending  out  1  MEM stage holds load with reg_write and dest != 0
protocol_err  out  1  sticky: mem_read and mem_write both set
retire_count  out  32  instructions completed write-back

Behaviour:
- Reset (rst=1 at a clk edge) clears both valid bits, all stored fields, protocol_err and retire_count to 0. Every output is therefore 0 after reset, except ex_ready, which follows !mem_stall. rst has priority over mem_stall and all other inputs.
- Accept: ex_valid && ex_ready at edge N loads the EX/MEM register (valid=1 plus all fields). ex_valid=0 with ex_ready=1 loads a bubble (valid=0).
- MEM cycle N+1:
  - dmem_addr = alu_result; dmem_wdata = store_data.
  - dmem_re = valid && mem_read && !mem_write.
  - dmem_we = valid && mem_write; a store has priority over a load.
- At edge N+1, if !mem_stall, MEM/WB captures valid, dest, reg_write, and wb data. wb data = mem_to_reg ? dmem_rdata : alu_result.
- WB cycle N+2: rf_we = valid && reg_write && dest != 0; rf_waddr = dest; rf_wdata = captured data. Total latency is 2 cycles from acceptance to the write-back cycle.
- mem_stall=1:
  - EX/MEM holds its contents and ex_ready=0; upstream must hold its inputs.
  - dmem_we stays asserted for the held store; memory commits on the cycle stall drops.
  - MEM/WB loads a bubble and still completes the instruction it already holds.
- fwd_mem_valid = EX/MEM valid && reg_write && !mem_to_reg && dest != 0. A load is never forwarded from MEM; hazard logic uses load_pending to stall ID.
- Register $0: writes to it are suppressed and it is never a forwarding source.
- protocol_err sets when an accepted, valid entry has mem_read && mem_write. It stays set until rst.
- retire_count increments by 1 each cycle the MEM/WB valid bit is 1 (bubbles excluded). It wraps 0xFFFFFFFF -> 0.
- Reset asserted mid-stall discards both stages, including any pending store; no memory or register write occurs in the reset cycle's aftermath.
- Outputs carry no combinational path from ex_* inputs; the only combinational path is dmem_rdata -> MEM/WB D input.

Decomposition:
- Shared package mips_pkg: DATA_W, REG_AW, REG_ZERO constant, and packed wb_ctrl_t {reg_write, mem_to_reg} and m_ctrl_t {mem_read, mem_write}. ID2EXE also uses these types.
- One sub-module, pipe_stage_reg: a parameterised-width register with valid bit, hold and bubble-insert. It is instantiated twice (EX/MEM, MEM/WB).

Test Plan:
- add: accept {alu=0x0000_0010, dest=8, reg_write=1, mem_to_reg=0} at edge 1 -> fwd_mem_valid=1/dest 8 in cycle 2; rf_we=1, rf_waddr=8, rf_wdata=0x10 in cycle 3; retire_count=1 after.
- load: mem_read=1, mem_to_reg=1, alu=0x20, dest=9, bench memory returns 0xDEADBEEF -> cycle 2 dmem_re=1, dmem_addr=0x20, load_pending=1, fwd_mem_valid=0; cycle 3 rf_wdata=0xDEADBEEF.
- store under stall: mem_write=1, alu=0x4, store=0x55, mem_stall=1 for 3 cycles -> dmem_we=1 and ex_ready=0 held 3 cycles; MEM/WB gets bubbles (rf_we=0); retire_count advances by exactly 1 after release.
- dest 0: reg_write=1, dest=0, alu=0x7 -> rf_we=0 and fwd_mem_valid=0 throughout; retire_count still increments.
- illegal control: mem_read=1 and mem_write=1 -> dmem_we=1, dmem_re=0, protocol_err=1 and stays 1 until rst.
- reset mid-pipe: two valid instructions in flight, rst=1 for one edge -> next cycle rf_we=0, dmem_we=0, all fwd_* 0, retire_count=0.
